apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
- APB completer (slave) that receives the bus driven by the team's AHB-to-APB bridge controller on one of its three Pselx lines.
- Tracks the SETUP/ACCESS protocol phases and decodes a word-addressed register bank: general read/write scratch registers, a read-only transfer-count status register, a write-1-to-clear error register and an interrupt-enable register.
- Supports optional wait states and flags protocol violations and bad accesses.
- Used as the bring-up and verification target for the bridge, and as the template for future peripherals.

Parameters:
- ADDR_BASE, 32'h8000_0000, base address; must be 1 KB aligned; decode compares Paddr[31:10].
- NUM_REGS, 16, total registers, range 4..256; indices 0..NUM_REGS-4 are scratch.
- WAIT_STATES, 0, extra ACCESS cycles inserted before Pready, range 0..15.
- SEL_INDEX, 0, which Pselx bit selects this slave, range 0..2.

Ports:
- Hclk  in  1  bus clock.
- Hresetn  in  1  asynchronous active-low reset.
- Pselx  in  3  one-hot slave selects from the bridge.
- Penable  in  1  APB enable (ACCESS phase).
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pwdata  in  32  write data.
- Prdata  out  32  read data, registered.
- Pready  out  1  transfer completes this cycle.
- Pslverr  out  1  error response, valid only while Pready is high.
- irq  out  1  level interrupt, |(ERR & IRQEN).

Behaviour:
- One clock, Hclk. Reset is asynchronous and active-low (Hresetn). Async assertion forces all state to zero at any point, including mid-transfer: Prdata=0, Pready=0, Pslverr=0, irq=0, all registers 0, FSM=IDLE. No partial write may survive reset.
- sel = Pselx[SEL_INDEX].
- Decode:
  - hit = Paddr[31:10]==ADDR_BASE[31:10]; idx = Paddr[9:2].
  - ok = hit & Paddr[1:0]==0 & idx<NUM_REGS.
  - ok=0 is a bad access.
- Register map by index:
  - 0..NUM_REGS-4: SCRATCH, read/write.
  - NUM_REGS-3: STATUS, read-only, {wr_cnt[15:0], rd_cnt[15:0]}.
  - NUM_REGS-2: ERR, W1C; bit0 protocol error, bit1 bad address, bit2 write to read-only; bits 31:3 read 0.
  - NUM_REGS-1: IRQEN, read/write, bits [2:0]; other bits read 0.
- FSM states: IDLE, ACCESS. A wait counter wcnt is 4 bits.
- IDLE:
  - sel & ~Penable (setup phase): latch Paddr, Pwrite, Pwdata; wcnt<=WAIT_STATES; go to ACCESS.
  - For a read, Prdata<=reg[idx] if ok, else 0, at this same edge, so Prdata is valid in the first ACCESS cycle.
  - sel & Penable: protocol error, ERR[0] set, no register effect, stay IDLE.
- ACCESS:
  - Pready = (wcnt==0) & sel & Penable & Paddr==latched addr & Pwrite==latched write. This is a combinational output from registered state plus bus inputs.
  - Pready=1: the transfer completes and the FSM returns to IDLE.
    - Write, ok, writable: commit latched Pwdata at this edge.
    - Read: rd_cnt++. Write: wr_cnt++. Both saturate at 16'hFFFF; the counters count only transfers with Pslverr=0.
    - Pslverr = ~ok | (write & idx is STATUS).
    - Set ERR[1] for a bad address; set ERR[2] for a read-only write.
    - With WAIT_STATES=0 every transfer is zero-wait, which the bridge requires because it has no Pready input.
  - Valid phase with wcnt!=0: wcnt--, Pready=0; re-read reg[idx] into Prdata each cycle.
  - Mismatch, ~sel or ~Penable while in ACCESS: abort with no commit and set ERR[0].
    - If sel & ~Penable in that cycle, treat it as a new setup and stay in ACCESS with a fresh latch.
    - Otherwise go to IDLE.
- ERR W1C: bits written 1 clear. A hardware set and a software clear on the same bit in the same edge: set wins.
- Back-to-back transfers (ACCESS then immediate setup next cycle) must sustain one transfer per two cycles.
- Pslverr=0 whenever Pready=0.

Decomposition:
- Package apb_pkg:
  - FSM state enum.
  - ERR bit position constants (ERR_PROTO=0, ERR_ADDR=1, ERR_RO=2).
  - Register index offset constants relative to NUM_REGS.
  - APB data and address widths (32).
- One natural sub-module, apb_slave_decode: combinational hit/ok/idx/read-only classification, shared with future peripherals.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to ADDR_BASE+0x4, then read it back -> Pready=1 in each ACCESS cycle, Prdata=32'hDEAD_BEEF, Pslverr=0, STATUS reads 32'h0001_0001 (one write, one read counted before the STATUS read itself).
- Write to STATUS (ADDR_BASE+0x34, NUM_REGS=16) -> Pslverr=1 with Pready, STATUS unchanged, ERR=3'b100. Then set IRQEN=4 -> irq=1. Then write ERR=4 -> ERR=0 and irq=0.
- Read ADDR_BASE+0x2 (unaligned) and ADDR_BASE+0x40 (out of range) -> Pslverr=1, Prdata=0, ERR[1]=1, counters unchanged.
- Penable=1 with no preceding setup, and separately Paddr changed between setup and access -> ERR[0]=1, no register written.
- WAIT_STATES=3, write -> Pready low for 3 ACCESS cycles, high on the 4th; data committed only at that edge.
- Drive Hresetn low mid-ACCESS of a write to SCRATCH[2] -> all outputs 0 immediately, SCRATCH[2]=0 after release; a subsequent transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for APB completers built on the register-bank template.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } apb_state_e;

  // ERR register bit positions
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_PROTO = 0;
  localparam int unsigned ERR_ADDR  = 1;
  localparam int unsigned ERR_RO    = 2;

  // Housekeeping registers sit at the top of the map, counted down from NUM_REGS
  localparam int unsigned OFF_STATUS = 3;
  localparam int unsigned OFF_ERR    = 2;
  localparam int unsigned OFF_IRQEN  = 1;

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational address decode for a 1 KB word-addressed register window.
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned       NUM_REGS  = 16
) (
  input  logic [APB_AW-1:0] paddr_i,
  output logic              ok_o,
  output logic [7:0]        idx_o,
  output logic              is_scratch_o,
  output logic              is_status_o,
  output logic              is_err_o,
  output logic              is_irqen_o,
  output logic              read_only_o
);

  logic hit;
  logic in_range;

  always_comb begin
    idx_o        = paddr_i[9:2];
    hit          = (paddr_i[31:10] == ADDR_BASE[31:10]);
    in_range     = (32'(idx_o) < NUM_REGS);
    ok_o         = hit & (paddr_i[1:0] == 2'b00) & in_range;
    is_scratch_o = ok_o & (32'(idx_o) < (NUM_REGS - OFF_STATUS));
    is_status_o  = ok_o & (32'(idx_o) == (NUM_REGS - OFF_STATUS));
    is_err_o     = ok_o & (32'(idx_o) == (NUM_REGS - OFF_ERR));
    is_irqen_o   = ok_o & (32'(idx_o) == (NUM_REGS - OFF_IRQEN));
    read_only_o  = is_status_o;
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer with scratch registers, transfer-count status, W1C error and IRQ enable.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       WAIT_STATES = 0,
  parameter int unsigned       SEL_INDEX   = 0
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic [2:0]        Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [APB_AW-1:0] Paddr,
  input  logic [APB_DW-1:0] Pwdata,
  output logic [APB_DW-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr,
  output logic              irq
);

  localparam int unsigned NUM_SCRATCH = NUM_REGS - OFF_STATUS;

  apb_state_e        state_q, state_d;
  logic [APB_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic [APB_DW-1:0] scratch_q [NUM_SCRATCH];
  logic [APB_DW-1:0] scratch_d [NUM_SCRATCH];
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ERR_W-1:0]  irqen_q, irqen_d;

  logic              sel, setup, valid, pready, pslverr, do_setup;
  logic [ERR_W-1:0]  err_set, err_clr;
  logic [APB_DW-1:0] rdata;

  logic              dec_ok, dec_scratch, dec_status, dec_err, dec_irqen, dec_ro;
  logic [7:0]        dec_idx;

  logic unused_sel;
  assign unused_sel = ^Pselx;

  // In ACCESS every committing path requires Paddr == addr_q, so decoding the live bus suffices.
  apb_slave_decode #(
    .ADDR_BASE (ADDR_BASE),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .paddr_i      (Paddr),
    .ok_o         (dec_ok),
    .idx_o        (dec_idx),
    .is_scratch_o (dec_scratch),
    .is_status_o  (dec_status),
    .is_err_o     (dec_err),
    .is_irqen_o   (dec_irqen),
    .read_only_o  (dec_ro)
  );

  always_comb begin
    sel     = Pselx[SEL_INDEX];
    setup   = sel & ~Penable;
    valid   = sel & Penable & (Paddr == addr_q) & (Pwrite == write_q);
    pready  = (state_q == StAccess) & (wcnt_q == 4'd0) & valid;
    pslverr = pready & (~dec_ok | (write_q & dec_ro));
  end

  always_comb begin
    rdata = '0;
    if (dec_scratch) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (dec_idx == 8'(i)) rdata = scratch_q[i];
      end
    end
    if (dec_status) rdata = {wr_cnt_q, rd_cnt_q};
    if (dec_err)    rdata = APB_DW'(err_q);
    if (dec_irqen)  rdata = APB_DW'(irqen_q);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    prdata_d  = prdata_q;
    scratch_d = scratch_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    irqen_d   = irqen_q;
    err_set   = '0;
    err_clr   = '0;
    do_setup  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (setup) begin
          do_setup = 1'b1;
        end else if (sel & Penable) begin
          err_set[ERR_PROTO] = 1'b1;
        end
      end
      StAccess: begin
        if (valid) begin
          if (wcnt_q == 4'd0) begin
            state_d = StIdle;
            if (pslverr) begin
              err_set[ERR_ADDR] = ~dec_ok;
              err_set[ERR_RO]   = dec_ok & write_q & dec_ro;
            end else if (write_q) begin
              for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (dec_scratch && dec_idx == 8'(i)) scratch_d[i] = wdata_q;
              end
              if (dec_err)   err_clr = wdata_q[ERR_W-1:0];
              if (dec_irqen) irqen_d = wdata_q[ERR_W-1:0];
              if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
              if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
          end else begin
            wcnt_d = wcnt_q - 4'd1;
            if (!write_q) prdata_d = rdata;
          end
        end else begin
          err_set[ERR_PROTO] = 1'b1;
          if (setup) do_setup = 1'b1;
          else       state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_setup) begin
      state_d = StAccess;
      addr_d  = Paddr;
      write_d = Pwrite;
      wdata_d = Pwdata;
      wcnt_d  = 4'(WAIT_STATES);
      if (!Pwrite) prdata_d = rdata;
    end

    // A hardware set beats a software clear on the same bit.
    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
      prdata_q <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= '0;
      irqen_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      prdata_q  <= prdata_d;
      scratch_q <= scratch_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
      irqen_q   <= irqen_d;
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready;
  assign Pslverr = pslverr;
  assign irq     = |(err_q & irqen_q);

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench: zero-wait instance on Pselx[0], three-wait instance on Pselx[1].
module tb_apb_slave_regbank;

  localparam logic [31:0] B = 32'h8000_0000;

  typedef struct {
    logic        chk;
    logic [31:0] rdata;
    logic        slverr;
    logic        irq;
  } sb_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1, irq0, irq1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  sb_t         sb_q[$];

  logic [31:0] scr_m [13];
  logic [15:0] wr_m, rd_m;
  logic [2:0]  err_m, irqen_m;

  apb_slave_regbank #(
    .ADDR_BASE(B), .NUM_REGS(16), .WAIT_STATES(0), .SEL_INDEX(0)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata0), .Pready(pready0),
    .Pslverr(pslverr0), .irq(irq0)
  );

  apb_slave_regbank #(
    .ADDR_BASE(B), .NUM_REGS(16), .WAIT_STATES(3), .SEL_INDEX(1)
  ) dut_ws (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata1), .Pready(pready1),
    .Pslverr(pslverr1), .irq(irq1)
  );

  always #5 Hclk = ~Hclk;
  always @(posedge Hclk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < 13; i++) scr_m[i] = '0;
    wr_m = '0; rd_m = '0; err_m = '0; irqen_m = '0;
  endtask

  // Reference behaviour of the zero-wait instance (NUM_REGS=16).
  task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d);
    sb_t         e;
    int unsigned i;
    bit          ok;
    i = 32'(a[9:2]);
    ok = (a[31:10] == B[31:10]) && (a[1:0] == 2'b00) && (i < 16);
    e.chk = !w; e.rdata = '0; e.slverr = 1'b0;
    if (!ok) begin
      e.slverr = 1'b1; err_m[1] = 1'b1;
    end else if (w) begin
      if (i == 13) begin
        e.slverr = 1'b1; err_m[2] = 1'b1;
      end else begin
        if (i < 13)       scr_m[i] = d;
        else if (i == 14) err_m = err_m & ~d[2:0];
        else              irqen_m = d[2:0];
        if (wr_m != 16'hFFFF) wr_m = wr_m + 16'd1;
      end
    end else begin
      if (i < 13)       e.rdata = scr_m[i];
      else if (i == 13) e.rdata = {wr_m, rd_m};
      else if (i == 14) e.rdata = {29'b0, err_m};
      else              e.rdata = {29'b0, irqen_m};
      if (rd_m != 16'hFFFF) rd_m = rd_m + 16'd1;
    end
    e.irq = |(err_m & irqen_m);
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic se, output int waits, output bit tmo);
    Pselx = 3'b001 << s; Pwrite = w; Paddr = a; Pwdata = d; Penable = 1'b0;
    @(posedge Hclk); #1 Penable = 1'b1;
    waits = 0; tmo = 1'b1; rd = '0; se = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Hclk);
      if ((s == 0) ? pready0 : pready1) begin
        rd = (s == 0) ? prdata0 : prdata1;
        se = (s == 0) ? pslverr0 : pslverr1;
        tmo = 1'b0;
        break;
      end
      waits++;
      @(posedge Hclk);
    end
    @(posedge Hclk); #1;
    Pselx = '0; Penable = 1'b0;
  endtask

  task automatic test_reset();
    Pselx = '0; Penable = 0; Pwrite = 0; Paddr = '0; Pwdata = '0;
    Hresetn = 1'b0;
    model_reset();
    repeat (3) @(posedge Hclk);
    #2;
    n_checks++; if (prdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", prdata0); end
    n_checks++; if (pready0 !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b want 0", pready0); end
    n_checks++; if (pslverr0 !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b want 0", pslverr0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq0); end
    n_checks++; if (pready1 !== 1'b0) begin n_fail++; $display("FAIL reset_pready_ws: got %b want 0", pready1); end
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
  endtask

  task automatic test_rw();
    op_t ops [3];
    logic [31:0] rd; logic se; int wt; bit tmo; sb_t e;
    ops = '{'{1'b1, B + 32'h4, 32'hDEAD_BEEF}, '{1'b0, B + 32'h4, 32'h0},
            '{1'b0, B + 32'h34, 32'h0}};
    for (int k = 0; k < 3; k++) begin
      model_push(ops[k].w, ops[k].a, ops[k].d);
      xfer(0, ops[k].w, ops[k].a, ops[k].d, rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || wt != 0 || se !== e.slverr || irq0 !== e.irq || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL rw[%0d]: rdata=%h slverr=%b irq=%b waits=%0d tmo=%0d; want rdata=%h slverr=%b irq=%b waits=0",
                 k, rd, se, irq0, wt, tmo, e.rdata, e.slverr, e.irq);
      end
    end
  endtask

  task automatic test_ro_irq();
    op_t ops [7];
    logic [31:0] rd; logic se; int wt; bit tmo; sb_t e;
    ops = '{'{1'b1, B + 32'h34, 32'hFFFF_FFFF}, '{1'b0, B + 32'h34, 32'h0},
            '{1'b0, B + 32'h38, 32'h0},         '{1'b1, B + 32'h3C, 32'h4},
            '{1'b0, B + 32'h3C, 32'h0},         '{1'b1, B + 32'h38, 32'h4},
            '{1'b0, B + 32'h38, 32'h0}};
    for (int k = 0; k < 7; k++) begin
      model_push(ops[k].w, ops[k].a, ops[k].d);
      xfer(0, ops[k].w, ops[k].a, ops[k].d, rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || se !== e.slverr || irq0 !== e.irq || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL ro_irq[%0d]: rdata=%h slverr=%b irq=%b tmo=%0d; want rdata=%h slverr=%b irq=%b",
                 k, rd, se, irq0, tmo, e.rdata, e.slverr, e.irq);
      end
    end
  endtask

  task automatic test_bad_addr();
    op_t ops [6];
    logic [31:0] rd; logic se; int wt; bit tmo; sb_t e;
    ops = '{'{1'b0, B + 32'h2, 32'h0},  '{1'b0, B + 32'h40, 32'h0},
            '{1'b1, 32'h4000_0004, 32'h1}, '{1'b0, B + 32'h34, 32'h0},
            '{1'b0, B + 32'h38, 32'h0}, '{1'b1, B + 32'h38, 32'h7}};
    for (int k = 0; k < 6; k++) begin
      model_push(ops[k].w, ops[k].a, ops[k].d);
      xfer(0, ops[k].w, ops[k].a, ops[k].d, rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || se !== e.slverr || irq0 !== e.irq || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL bad_addr[%0d]: rdata=%h slverr=%b irq=%b tmo=%0d; want rdata=%h slverr=%b irq=%b",
                 k, rd, se, irq0, tmo, e.rdata, e.slverr, e.irq);
      end
    end
  endtask

  task automatic test_protocol();
    op_t ops [4];
    logic [31:0] rd; logic se; int wt; bit tmo; sb_t e;
    // Penable with no setup phase
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = B; Pwdata = 32'hFFFF_FFFF;
    @(negedge Hclk);
    n_checks++; if (pready0 !== 1'b0) begin n_fail++; $display("FAIL proto_nosetup_pready: got %b want 0", pready0); end
    @(posedge Hclk); #1 Pselx = '0; Penable = 1'b0;
    err_m[0] = 1'b1;
    // Address changes between setup and access
    Pselx = 3'b001; Pwrite = 1'b1; Paddr = B; Pwdata = 32'h1111_1111;
    @(posedge Hclk); #1 Penable = 1'b1; Paddr = B + 32'h4;
    @(negedge Hclk);
    n_checks++; if (pready0 !== 1'b0) begin n_fail++; $display("FAIL proto_addrchg_pready: got %b want 0", pready0); end
    @(posedge Hclk); #1 Pselx = '0; Penable = 1'b0;
    // Abort by a fresh setup during ACCESS; the new read must complete
    Pselx = 3'b001; Pwrite = 1'b1; Paddr = B; Pwdata = 32'h2222_2222;
    @(posedge Hclk); #1 Pwrite = 1'b0; Paddr = B + 32'h4;
    model_push(1'b0, B + 32'h4, 32'h0);
    @(posedge Hclk); #1 Penable = 1'b1;
    @(negedge Hclk);
    e = sb_q.pop_front();
    n_checks++;
    if (pready0 !== 1'b1 || prdata0 !== e.rdata || pslverr0 !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_resetup: pready=%b rdata=%h slverr=%b; want pready=1 rdata=%h slverr=0",
               pready0, prdata0, pslverr0, e.rdata);
    end
    @(posedge Hclk); #1 Pselx = '0; Penable = 1'b0;
    ops = '{'{1'b0, B, 32'h0}, '{1'b0, B + 32'h38, 32'h0},
            '{1'b1, B + 32'h38, 32'h7}, '{1'b0, B + 32'h38, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      model_push(ops[k].w, ops[k].a, ops[k].d);
      xfer(0, ops[k].w, ops[k].a, ops[k].d, rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || se !== e.slverr || irq0 !== e.irq || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL proto[%0d]: rdata=%h slverr=%b irq=%b tmo=%0d; want rdata=%h slverr=%b irq=%b",
                 k, rd, se, irq0, tmo, e.rdata, e.slverr, e.irq);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic se; int wt; bit tmo; sb_t e; int c0;
    logic [31:0] a; logic w;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      w = (k < 4);
      a = B + 32'h8 + 32'(4 * (k % 4));
      model_push(w, a, 32'hA000_0000 + 32'(k * 32'h0101));
      xfer(0, w, a, 32'hA000_0000 + 32'(k * 32'h0101), rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || wt != 0 || se !== e.slverr || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: rdata=%h slverr=%b waits=%0d; want rdata=%h slverr=%b waits=0",
                 k, rd, se, wt, e.rdata, e.slverr);
      end
    end
    n_checks++;
    if (cyc - c0 != 16) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 16", cyc - c0); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic se; int wt; bit tmo;
    logic [31:0] ra [3];
    logic [31:0] rexp [3];
    xfer(1, 1'b1, B, 32'hA5A5_A5A5, rd, se, wt, tmo);
    n_checks++;
    if (tmo || wt != 3 || se !== 1'b0) begin
      n_fail++; $display("FAIL ws_write: waits=%0d slverr=%b tmo=%0d; want waits=3 slverr=0", wt, se, tmo);
    end
    // Abort a write after two wait cycles: nothing may be committed
    Pselx = 3'b010; Pwrite = 1'b1; Paddr = B + 32'h4; Pwdata = 32'h1234_5678; Penable = 1'b0;
    @(posedge Hclk); #1 Penable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge Hclk);
      n_checks++;
      if (pready1 !== 1'b0) begin n_fail++; $display("FAIL ws_abort_pready[%0d]: got %b want 0", c, pready1); end
      @(posedge Hclk);
    end
    #1 Pselx = '0; Penable = 1'b0;
    @(posedge Hclk); #1;
    ra   = '{B + 32'h4, B, B + 32'h38};
    rexp = '{32'h0, 32'hA5A5_A5A5, 32'h1};
    for (int k = 0; k < 3; k++) begin
      xfer(1, 1'b0, ra[k], 32'h0, rd, se, wt, tmo);
      n_checks++;
      if (tmo || wt != 3 || se !== 1'b0 || rd !== rexp[k]) begin
        n_fail++;
        $display("FAIL ws_read[%0d]: rdata=%h waits=%0d slverr=%b; want rdata=%h waits=3 slverr=0",
                 k, rd, wt, se, rexp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t ops [4];
    logic [31:0] rd; logic se; int wt; bit tmo; sb_t e;
    ops = '{'{1'b1, B + 32'h3C, 32'h4}, '{1'b1, B + 32'h34, 32'h0},
            '{1'b0, B + 32'h4, 32'h0},  '{1'b0, B + 32'h4, 32'h0}};
    for (int k = 0; k < 3; k++) begin
      model_push(ops[k].w, ops[k].a, ops[k].d);
      xfer(0, ops[k].w, ops[k].a, ops[k].d, rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || se !== e.slverr || irq0 !== e.irq || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL rst_pre[%0d]: rdata=%h slverr=%b irq=%b; want rdata=%h slverr=%b irq=%b",
                 k, rd, se, irq0, e.rdata, e.slverr, e.irq);
      end
    end
    Pselx = 3'b001; Pwrite = 1'b1; Paddr = B + 32'h8; Pwdata = 32'hCAFE_F00D; Penable = 1'b0;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(negedge Hclk);
    n_checks++; if (pready0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pready_before: got %b want 1", pready0); end
    #2 Hresetn = 1'b0;
    #1;
    n_checks++;
    if (prdata0 !== 32'h0 || pready0 !== 1'b0 || pslverr0 !== 1'b0 || irq0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: prdata=%h pready=%b slverr=%b irq=%b; want all 0",
               prdata0, pready0, pslverr0, irq0);
    end
    Pselx = '0; Penable = 1'b0;
    model_reset();
    @(posedge Hclk); #3 Hresetn = 1'b1;
    ops = '{'{1'b0, B + 32'h8, 32'h0}, '{1'b1, B + 32'h8, 32'h55AA_55AA},
            '{1'b0, B + 32'h8, 32'h0}, '{1'b0, B + 32'h34, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      model_push(ops[k].w, ops[k].a, ops[k].d);
      xfer(0, ops[k].w, ops[k].a, ops[k].d, rd, se, wt, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || se !== e.slverr || irq0 !== e.irq || (e.chk && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL rst_post[%0d]: rdata=%h slverr=%b irq=%b; want rdata=%h slverr=%b irq=%b",
                 k, rd, se, irq0, e.rdata, e.slverr, e.irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_ro_irq();
    test_bad_addr();
    test_protocol();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
